// File: rtl/secuenciador_corte_pkg.sv
// Shared constants and state encoding for the cut-pattern sequencer.
package secuenciador_corte_pkg;

  localparam int unsigned ANCHO_DATO = 12;
  localparam int unsigned ANCHO_DIR  = 9;

  localparam logic [ANCHO_DATO-1:0] MARCA_FIN  = 12'hFFF;
  localparam logic [ANCHO_DIR-1:0]  DIR_ULTIMA = 9'd511;

  typedef enum logic [2:0] {
    StReposo,
    StCarga,
    StLeer,
    StEspera,
    StEvalua,
    StPresenta
  } estado_e;

endpackage

// File: rtl/secuenciador_corte.sv
// Load/run sequencer in front of the 512x12 cut-pattern RAM: sequential load from address 0,
// then read-back with a valid/listo handshake until the end marker or the last address.
module secuenciador_corte
  import secuenciador_corte_pkg::*;
(
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  iniciar_carga_i,
  input  logic                  cargar_valido_i,
  input  logic [ANCHO_DATO-1:0] cargar_dato_i,
  output logic                  cargar_listo_o,
  input  logic                  iniciar_corte_i,
  output logic                  palabra_valida_o,
  output logic [ANCHO_DATO-1:0] palabra_o,
  input  logic                  palabra_listo_i,
  output logic                  terminado_o,
  output logic                  error_desborde_o,
  output logic                  ocupado_o,
  output logic                  leer_escribir_memoria_o,
  output logic [ANCHO_DIR-1:0]  direccion_memoria_o,
  output logic [ANCHO_DATO-1:0] dato_escribir_memoria_o,
  input  logic [ANCHO_DATO-1:0] dato_leer_memoria_i,
  input  logic                  corte_terminado_i
);

  estado_e               estado_q, estado_d;
  logic [ANCHO_DIR-1:0]  ptr_q, ptr_d;
  logic [ANCHO_DATO-1:0] palabra_q, palabra_d;
  logic                  valida_q, valida_d;
  logic                  terminado_q, terminado_d;
  logic                  error_q, error_d;
  logic                  acepta;

  // Gated by reset so a word presented in the reset cycle is never written.
  assign acepta = (estado_q == StCarga) && cargar_valido_i && !reset_i;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      estado_q    <= StReposo;
      ptr_q       <= '0;
      palabra_q   <= '0;
      valida_q    <= 1'b0;
      terminado_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      ptr_q       <= ptr_d;
      palabra_q   <= palabra_d;
      valida_q    <= valida_d;
      terminado_q <= terminado_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    estado_d    = estado_q;
    ptr_d       = ptr_q;
    palabra_d   = palabra_q;
    valida_d    = valida_q;
    terminado_d = 1'b0;
    error_d     = error_q;

    unique case (estado_q)
      StReposo: begin
        if (iniciar_carga_i) begin
          estado_d = StCarga;
          ptr_d    = '0;
          error_d  = 1'b0;
        end else if (iniciar_corte_i) begin
          estado_d = StLeer;
          ptr_d    = '0;
          error_d  = 1'b0;
        end
      end

      StCarga: begin
        if (acepta) begin
          if (ptr_q == DIR_ULTIMA) begin
            error_d  = 1'b1;
            estado_d = StReposo;
          end else if (cargar_dato_i == MARCA_FIN) begin
            estado_d = StReposo;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end

      StLeer:   estado_d = StEspera;
      StEspera: estado_d = StEvalua;

      StEvalua: begin
        if (corte_terminado_i) begin
          terminado_d = 1'b1;
          estado_d    = StReposo;
        end else begin
          palabra_d = dato_leer_memoria_i;
          valida_d  = 1'b1;
          estado_d  = StPresenta;
        end
      end

      StPresenta: begin
        if (palabra_listo_i) begin
          valida_d = 1'b0;
          if (ptr_q == DIR_ULTIMA) begin
            error_d     = 1'b1;
            terminado_d = 1'b1;
            estado_d    = StReposo;
          end else begin
            ptr_d    = ptr_q + 1'b1;
            estado_d = StLeer;
          end
        end
      end

      default: estado_d = StReposo;
    endcase
  end

  assign cargar_listo_o          = acepta;
  assign leer_escribir_memoria_o = acepta;
  assign dato_escribir_memoria_o = acepta ? cargar_dato_i : '0;
  // Pointer drives the RAM in every active state, so the read address stays put while waiting.
  assign direccion_memoria_o     = (estado_q == StReposo) ? '0 : ptr_q;
  assign ocupado_o               = (estado_q != StReposo);
  assign palabra_valida_o        = valida_q;
  assign palabra_o               = palabra_q;
  assign terminado_o             = terminado_q;
  assign error_desborde_o        = error_q;

endmodule

// File: tb/tb_secuenciador_corte.sv
// Directed bench for secuenciador_corte with a 512x12 registered-read RAM model.
module tb_secuenciador_corte;
  import secuenciador_corte_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iniciar_carga = 1'b0, iniciar_corte = 1'b0;
  logic        cargar_valido = 1'b0, palabra_listo = 1'b0;
  logic [11:0] cargar_dato = '0;
  logic        cargar_listo, palabra_valida, terminado, error_desborde, ocupado, wea;
  logic [11:0] palabra, din, rdata;
  logic [8:0]  addr;
  logic        corte_terminado;

  logic [11:0] mem [512];
  logic [11:0] pat [16];
  logic [11:0] words_got [600];
  int          k_got [600];
  int          nvalid, nterm, tk;
  int          wea_count = 0;
  int          tests = 0, fails = 0;
  int          w0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wea) mem[addr] <= din;
    rdata <= mem[addr];
    if (wea) wea_count <= wea_count + 1;
  end

  assign corte_terminado = (rdata == MARCA_FIN);

  secuenciador_corte dut (
    .clock_i                 (clk),
    .reset_i                 (rst),
    .iniciar_carga_i         (iniciar_carga),
    .cargar_valido_i         (cargar_valido),
    .cargar_dato_i           (cargar_dato),
    .cargar_listo_o          (cargar_listo),
    .iniciar_corte_i         (iniciar_corte),
    .palabra_valida_o        (palabra_valida),
    .palabra_o               (palabra),
    .palabra_listo_i         (palabra_listo),
    .terminado_o             (terminado),
    .error_desborde_o        (error_desborde),
    .ocupado_o               (ocupado),
    .leer_escribir_memoria_o (wea),
    .direccion_memoria_o     (addr),
    .dato_escribir_memoria_o (din),
    .dato_leer_memoria_i     (rdata),
    .corte_terminado_i       (corte_terminado)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string nm);
    tests++;
    if ({palabra_valida, palabra, terminado, error_desborde, ocupado, wea, addr, din,
         cargar_listo} !== '0) begin
      fails++;
      $display("FAIL %s: outputs v=%b p=%h t=%b e=%b o=%b we=%b a=%h d=%h l=%b, want all 0",
               nm, palabra_valida, palabra, terminado, error_desborde, ocupado, wea, addr, din,
               cargar_listo);
    end
  endtask

  // Loads n words (pat[i], or i itself when ramp) and checks each write as it happens.
  task automatic load(input int n, input bit ramp);
    logic [11:0] w;
    iniciar_carga = 1'b1;
    step();
    iniciar_carga = 1'b0;
    for (int i = 0; i < n; i++) begin
      w = ramp ? i[11:0] : pat[i];
      cargar_valido = 1'b1;
      cargar_dato   = w;
      #1;
      tests++;
      if (wea !== 1'b1 || cargar_listo !== 1'b1 || addr !== i[8:0] || din !== w) begin
        fails++;
        $display("FAIL load_write[%0d]: we=%b listo=%b addr=%0d din=%h, want 1 1 %0d %h",
                 i, wea, cargar_listo, addr, din, i, w);
      end
      step();
    end
    cargar_valido = 1'b0;
    tests++;
    if (ocupado !== 1'b0) begin
      fails++;
      $display("FAIL load_end_idle: ocupado=%b want 0", ocupado);
    end
  endtask

  task automatic start_run();
    iniciar_corte = 1'b1;
    step();
    iniciar_corte = 1'b0;
  endtask

  // Samples from cycle k0 after iniciar_corte; stops 3 cycles after terminado or at maxk.
  task automatic run_collect(input int k0, input int maxk);
    nvalid = 0;
    nterm  = 0;
    tk     = -1;
    for (int k = k0; k <= maxk; k++) begin
      if (palabra_valida === 1'b1 && nvalid < 600) begin
        words_got[nvalid] = palabra;
        k_got[nvalid]     = k;
        nvalid++;
      end
      if (terminado === 1'b1) begin
        nterm++;
        tk = k;
      end
      if (nterm > 0 && k >= tk + 3) break;
      step();
    end
    tests++;
    if (nterm == 0) begin
      fails++;
      $display("FAIL run_timeout: no terminado within %0d cycles", maxk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    check_all_zero("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_basic();
    pat[0] = 12'h003; pat[1] = 12'h005; pat[2] = 12'h007; pat[3] = 12'hFFF;
    w0 = wea_count;
    load(4, 1'b0);
    tests++;
    if (wea_count - w0 != 4) begin
      fails++; $display("FAIL basic_wea_cycles: got %0d want 4", wea_count - w0);
    end
    palabra_listo = 1'b1;
    start_run();
    run_collect(1, 60);
    tests++;
    if (nvalid != 3) begin fails++; $display("FAIL basic_nvalid: got %0d want 3", nvalid); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (nvalid > i && (words_got[i] !== pat[i] || k_got[i] != 4 + 4 * i)) begin
        fails++;
        $display("FAIL basic_word[%0d]: got %h at k=%0d want %h at k=%0d",
                 i, words_got[i], k_got[i], pat[i], 4 + 4 * i);
      end
    end
    tests++;
    if (nterm != 1 || tk != 16) begin
      fails++; $display("FAIL basic_terminado: got %0d pulses at k=%0d want 1 at 16", nterm, tk);
    end
    tests++;
    if (error_desborde !== 1'b0) begin
      fails++; $display("FAIL basic_error: got %b want 0", error_desborde);
    end
  endtask

  task automatic test_empty();
    pat[0] = 12'hFFF;
    load(1, 1'b0);
    start_run();
    run_collect(1, 30);
    tests++;
    if (nvalid != 0 || tk != 4) begin
      fails++; $display("FAIL empty_run: got %0d words, term k=%0d want 0 words, k=4", nvalid, tk);
    end
  endtask

  task automatic test_backpressure();
    pat[0] = 12'h005; pat[1] = 12'h009; pat[2] = 12'hFFF;
    load(3, 1'b0);
    palabra_listo = 1'b0;
    start_run();
    step(); step(); step();
    tests++;
    if (palabra_valida !== 1'b1 || palabra !== 12'h005) begin
      fails++; $display("FAIL bp_first: got v=%b p=%h want 1 005", palabra_valida, palabra);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if (palabra_valida !== 1'b1 || palabra !== 12'h005 || addr !== 9'd0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got v=%b p=%h a=%0d want 1 005 0",
                 i, palabra_valida, palabra, addr);
      end
    end
    palabra_listo = 1'b1;
    step();
    palabra_listo = 1'b0;
    tests++;
    if (palabra_valida !== 1'b0) begin
      fails++; $display("FAIL bp_drop: got v=%b want 0", palabra_valida);
    end
    step(); step(); step();
    tests++;
    if (palabra_valida !== 1'b1 || palabra !== 12'h009 || addr !== 9'd1) begin
      fails++;
      $display("FAIL bp_next: got v=%b p=%h a=%0d want 1 009 1", palabra_valida, palabra, addr);
    end
    palabra_listo = 1'b1;
    run_collect(1, 30);
    tests++;
    if (nvalid != 1 || tk != 5) begin
      fails++; $display("FAIL bp_end: got %0d words, term k=%0d want 1, k=5", nvalid, tk);
    end
  endtask

  task automatic test_overflow();
    load(512, 1'b1);
    tests++;
    if (error_desborde !== 1'b1) begin
      fails++; $display("FAIL ovf_load_error: got %b want 1", error_desborde);
    end
    palabra_listo = 1'b1;
    start_run();
    tests++;
    if (error_desborde !== 1'b0) begin
      fails++; $display("FAIL ovf_error_cleared: got %b want 0", error_desborde);
    end
    run_collect(1, 2200);
    tests++;
    if (nvalid != 512 || words_got[511] !== 12'd511 || nterm != 1 || tk != 2049) begin
      fails++;
      $display("FAIL ovf_run: got %0d words last %h, %0d term at k=%0d want 512 1ff 1 2049",
               nvalid, words_got[511], nterm, tk);
    end
    tests++;
    if (error_desborde !== 1'b1 || ocupado !== 1'b0) begin
      fails++;
      $display("FAIL ovf_run_error: got e=%b o=%b want 1 0", error_desborde, ocupado);
    end
  endtask

  task automatic test_reset_mid();
    pat[0] = 12'h001; pat[1] = 12'h002; pat[2] = 12'hFFF;
    load(3, 1'b0);
    palabra_listo = 1'b0;
    start_run();
    step(); step(); step();
    tests++;
    if (palabra_valida !== 1'b1) begin
      fails++; $display("FAIL rst_presenta_pre: got v=%b want 1", palabra_valida);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("rst_presenta");
    iniciar_carga = 1'b1;
    step();
    iniciar_carga = 1'b0;
    w0 = wea_count;
    cargar_valido = 1'b1;
    cargar_dato = 12'h044;
    step();
    cargar_dato = 12'h055;
    step();
    cargar_dato = 12'h066;
    rst = 1'b1;
    step();
    check_all_zero("rst_carga");
    rst = 1'b0;
    #1;
    tests++;
    if (wea !== 1'b0 || cargar_listo !== 1'b0) begin
      fails++; $display("FAIL rst_carga_nowrite: got we=%b listo=%b want 0 0", wea, cargar_listo);
    end
    step();
    cargar_valido = 1'b0;
    step();
    tests++;
    if (wea_count - w0 != 2 || mem[1] !== 12'h055 || mem[2] !== 12'hFFF) begin
      fails++;
      $display("FAIL rst_carga_mem: got %0d writes mem1=%h mem2=%h want 2 055 fff",
               wea_count - w0, mem[1], mem[2]);
    end
  endtask

  task automatic test_priority();
    iniciar_carga = 1'b1;
    iniciar_corte = 1'b1;
    step();
    iniciar_carga = 1'b0;
    iniciar_corte = 1'b0;
    cargar_valido = 1'b1;
    cargar_dato = 12'h008;
    #1;
    tests++;
    if (ocupado !== 1'b1 || cargar_listo !== 1'b1 || wea !== 1'b1) begin
      fails++;
      $display("FAIL prio_carga: got o=%b listo=%b we=%b want 1 1 1", ocupado, cargar_listo, wea);
    end
    step();
    cargar_dato = 12'hFFF;
    step();
    cargar_valido = 1'b0;
    palabra_listo = 1'b1;
    w0 = wea_count;
    start_run();
    step();
    iniciar_corte = 1'b1;
    iniciar_carga = 1'b1;
    step();
    iniciar_corte = 1'b0;
    iniciar_carga = 1'b0;
    run_collect(3, 30);
    tests++;
    if (nvalid != 1 || words_got[0] !== 12'h008 || k_got[0] != 4 || tk != 8) begin
      fails++;
      $display("FAIL prio_ignore: got %0d words first %h at k=%0d term k=%0d want 1 008 4 8",
               nvalid, words_got[0], k_got[0], tk);
    end
    tests++;
    if (wea_count != w0) begin
      fails++; $display("FAIL prio_no_write: got %0d writes want 0", wea_count - w0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
